// File: rtl/ct_select_n.sv
// ---------------------------------------------------------------------------
// ct_select_n : Wishbone 1-to-N address-decoding slave selector.
//
// One Wishbone master is fanned out to SLAVES slaves. Request fields are
// broadcast to every slave; only the decoded slave receives a strobe. The
// response of the active slave is returned combinationally to the master, so
// a slave that answers in the request cycle adds no latency. A small FSM
// locks the selected slave across wait states and incrementing/constant
// bursts. It also issues a one-cycle error for unmapped addresses and for
// slaves that stay silent for TIMEOUT strobed cycles.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   m_*_i               master request (dat, adr, sel, we, cyc, stb, cti, bte)
//   m_ack_o/err_o/rty_o master response, m_dat_o read data
//   s_*_o               flattened slave requests, slave i at slice i
//   s_ack_i/err_i/rty_i flattened slave responses, s_dat_i slave read data
//   timeout_o           one-cycle pulse while a timeout error is reported
// ---------------------------------------------------------------------------
module ct_select_n #(
   parameter int                    SLAVES  = 2,
   parameter logic [SLAVES*32-1:0]  S_BASE  = {4'hE, 28'h0, 32'h0},
   parameter logic [SLAVES*32-1:0]  S_MASK  = {32'hF000_0000, 32'h8000_0000},
   parameter int                    TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           m_dat_i,
   input  logic [31:0]           m_adr_i,
   input  logic [3:0]            m_sel_i,
   input  logic                  m_we_i,
   input  logic                  m_cyc_i,
   input  logic                  m_stb_i,
   input  logic [2:0]            m_cti_i,
   input  logic [1:0]            m_bte_i,
   output logic                  m_ack_o,
   output logic                  m_err_o,
   output logic                  m_rty_o,
   output logic [31:0]           m_dat_o,
   output logic [SLAVES*32-1:0]  s_dat_o,
   output logic [SLAVES*32-1:0]  s_adr_o,
   output logic [SLAVES*4-1:0]   s_sel_o,
   output logic [SLAVES-1:0]     s_we_o,
   output logic [SLAVES-1:0]     s_cyc_o,
   output logic [SLAVES-1:0]     s_stb_o,
   output logic [SLAVES*3-1:0]   s_cti_o,
   output logic [SLAVES*2-1:0]   s_bte_o,
   input  logic [SLAVES-1:0]     s_ack_i,
   input  logic [SLAVES-1:0]     s_err_i,
   input  logic [SLAVES-1:0]     s_rty_i,
   input  logic [SLAVES*32-1:0]  s_dat_i,
   output logic                  timeout_o
);

   localparam int         IW     = (SLAVES > 1) ? $clog2(SLAVES) : 1;
   localparam logic [7:0] TO_LIM = 8'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_ERROR} state_t;

   state_t          state;
   logic [7:0]      cnt;
   logic [IW-1:0]   lat_idx;

   logic [IW-1:0]   dec_idx;
   logic            dec_hit;
   logic [IW-1:0]   act_idx;
   logic            act_hit;
   logic            sel_vld;
   logic            ack_sel;
   logic            err_sel;
   logic            rty_sel;
   logic            resp;
   logic            burst;

   // Request fields go to every slave untouched; only stb is steered.
   assign s_dat_o = {SLAVES{m_dat_i}};
   assign s_adr_o = {SLAVES{m_adr_i}};
   assign s_sel_o = {SLAVES{m_sel_i}};
   assign s_we_o  = {SLAVES{m_we_i}};
   assign s_cyc_o = {SLAVES{m_cyc_i}};
   assign s_cti_o = {SLAVES{m_cti_i}};
   assign s_bte_o = {SLAVES{m_bte_i}};

   // Scan from the top index down so the lowest hitting window is the one
   // left standing when windows overlap.
   always_comb begin
      dec_hit = 1'b0;
      dec_idx = '0;
      for (int k = SLAVES - 1; k >= 0; k--) begin
         if ((m_adr_i & S_MASK[k*32 +: 32]) == (S_BASE[k*32 +: 32] & S_MASK[k*32 +: 32])) begin
            dec_hit = 1'b1;
            dec_idx = IW'(k);
         end
      end
   end

   // In ACTIVE the latched slave stays selected whatever the address does,
   // which is what keeps a burst on one slave. ERROR selects nobody.
   assign act_idx = (state == ST_ACTIVE) ? lat_idx : dec_idx;
   assign act_hit = (state == ST_ACTIVE) | ((state == ST_IDLE) & dec_hit);
   assign sel_vld = m_stb_i & act_hit;

   // Only the selected slave is strobed and listened to; anything another
   // slave drives onto its response lines is dropped here.
   always_comb begin
      s_stb_o = '0;
      m_dat_o = '0;
      ack_sel = 1'b0;
      err_sel = 1'b0;
      rty_sel = 1'b0;
      for (int k = 0; k < SLAVES; k++) begin
         if (sel_vld && (act_idx == IW'(k))) begin
            s_stb_o[k] = 1'b1;
            m_dat_o    = s_dat_i[k*32 +: 32];
            ack_sel    = s_ack_i[k];
            err_sel    = s_err_i[k];
            rty_sel    = s_rty_i[k];
         end
      end
   end

   assign m_ack_o = ack_sel;
   assign m_rty_o = rty_sel;
   assign m_err_o = err_sel | (state == ST_ERROR);
   assign resp    = ack_sel | err_sel | rty_sel;
   assign burst   = (m_cti_i == 3'b001) || (m_cti_i == 3'b010);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= 8'd0;
         lat_idx   <= '0;
         timeout_o <= 1'b0;
      end else begin
         timeout_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               cnt <= 8'd0;
               if (m_cyc_i && m_stb_i) begin
                  if (!dec_hit) begin
                     state <= ST_ERROR;
                  end else if (!resp) begin
                     // Answered-in-cycle transfers never leave IDLE.
                     lat_idx <= dec_idx;
                     state   <= ST_ACTIVE;
                  end
               end
            end
            ST_ACTIVE: begin
               if (!m_cyc_i) begin
                  state <= ST_IDLE;
                  cnt   <= 8'd0;
               end else if (resp) begin
                  // A response always beats a timeout hitting the same cycle.
                  cnt <= 8'd0;
                  if (!burst) state <= ST_IDLE;
               end else if (m_stb_i) begin
                  if ((TIMEOUT != 0) && (cnt == TO_LIM)) begin
                     state     <= ST_ERROR;
                     timeout_o <= 1'b1;
                     cnt       <= 8'd0;
                  end else begin
                     cnt <= cnt + 8'd1;
                  end
               end
            end
            ST_ERROR: begin
               state <= ST_IDLE;
               cnt   <= 8'd0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ct_select_n.sv
module tb_ct_select_n;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] m_dat_i, m_adr_i;
   logic [3:0]  m_sel_i;
   logic        m_we_i, m_cyc_i, m_stb_i;
   logic [2:0]  m_cti_i;
   logic [1:0]  m_bte_i;
   logic [1:0]  s_ack_i, s_err_i, s_rty_i;
   logic [63:0] s_dat_i;

   // DUT A: default windows, short timeout
   logic        m_ack_o, m_err_o, m_rty_o, timeout_o;
   logic [31:0] m_dat_o;
   logic [63:0] s_dat_o, s_adr_o;
   logic [7:0]  s_sel_o;
   logic [1:0]  s_we_o, s_cyc_o, s_stb_o;
   logic [5:0]  s_cti_o;
   logic [3:0]  s_bte_o;

   // DUT B: fully overlapping windows
   logic        b_ack, b_err, b_rty, b_timeout;
   logic [31:0] b_dat;
   logic [63:0] b_s_dat, b_s_adr;
   logic [7:0]  b_s_sel;
   logic [1:0]  b_s_we, b_s_cyc, b_s_stb;
   logic [5:0]  b_s_cti;
   logic [3:0]  b_s_bte;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];
   logic [31:0] want;

   always #5 clk = ~clk;

   ct_select_n #(.SLAVES(2), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .m_dat_i(m_dat_i), .m_adr_i(m_adr_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
      .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o), .m_dat_o(m_dat_o),
      .s_dat_o(s_dat_o), .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
      .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_dat_i(s_dat_i),
      .timeout_o(timeout_o)
   );

   ct_select_n #(.SLAVES(2), .S_MASK(64'h0), .TIMEOUT(255)) dut_b (
      .clk(clk), .rst(rst),
      .m_dat_i(m_dat_i), .m_adr_i(m_adr_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
      .m_ack_o(b_ack), .m_err_o(b_err), .m_rty_o(b_rty), .m_dat_o(b_dat),
      .s_dat_o(b_s_dat), .s_adr_o(b_s_adr), .s_sel_o(b_s_sel), .s_we_o(b_s_we),
      .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_cti_o(b_s_cti), .s_bte_o(b_s_bte),
      .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_dat_i(s_dat_i),
      .timeout_o(b_timeout)
   );

   // Drive one bus cycle just after the rising edge, return at the falling
   // edge so the caller samples settled outputs.
   task automatic drv(input logic cyc, input logic stb, input logic [31:0] adr,
                      input logic [2:0] cti, input logic [1:0] ack, input logic [63:0] dat);
      @(posedge clk);
      #1;
      m_cyc_i = cyc;
      m_stb_i = stb;
      m_adr_i = adr;
      m_cti_i = cti;
      s_ack_i = ack;
      s_dat_i = dat;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      m_dat_i = 32'h0; m_adr_i = 32'h0; m_sel_i = 4'h0; m_we_i = 1'b0;
      m_cyc_i = 1'b0; m_stb_i = 1'b0; m_cti_i = 3'b000; m_bte_i = 2'b00;
      s_ack_i = 2'b11; s_err_i = 2'b11; s_rty_i = 2'b11;
      s_dat_i = {32'h1111_1111, 32'h2222_2222};
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (m_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", m_err_o); end
      n_cmp++; if (m_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", m_ack_o); end
      n_cmp++; if (m_rty_o !== 1'b0) begin n_fail++; $display("FAIL reset_rty: got %b want 0", m_rty_o); end
      n_cmp++; if (m_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h want 0", m_dat_o); end
      n_cmp++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
      n_cmp++; if (s_stb_o !== 2'b00) begin n_fail++; $display("FAIL reset_stb: got %b want 00", s_stb_o); end
      s_err_i = 2'b00; s_rty_i = 2'b00;
      drv(1'b0, 1'b0, 32'h0, 3'b000, 2'b00, 64'h0);
   endtask

   task automatic test_single_read;
      m_sel_i = 4'hF; m_dat_i = 32'hCAFE_0001;
      exp_q.push_back(32'hA5A5_0001);
      drv(1'b1, 1'b1, 32'h0000_0010, 3'b000, 2'b01, {32'hBBBB_0001, 32'hA5A5_0001});
      n_cmp++; if (s_stb_o !== 2'b01) begin n_fail++; $display("FAIL single_stb: got %b want 01", s_stb_o); end
      n_cmp++; if (s_adr_o !== {2{32'h0000_0010}}) begin n_fail++; $display("FAIL single_adr_bcast: got %h", s_adr_o); end
      n_cmp++; if (s_dat_o !== {2{32'hCAFE_0001}} || s_sel_o !== 8'hFF) begin n_fail++; $display("FAIL single_bcast: got dat %h sel %h", s_dat_o, s_sel_o); end
      n_cmp++; if (m_ack_o !== 1'b1) begin n_fail++; $display("FAIL single_ack: got %b want 1", m_ack_o); end
      if (m_ack_o === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin n_fail++; $display("FAIL sb_single: unexpected ack, data %h", m_dat_o); end
         else begin want = exp_q.pop_front(); if (m_dat_o !== want) begin n_fail++; $display("FAIL sb_single: got %h want %h", m_dat_o, want); end end
      end
      // back-to-back beat re-decodes to slave 1: proves the FSM stayed in IDLE
      exp_q.push_back(32'hBBBB_0002);
      drv(1'b1, 1'b1, 32'hE000_0000, 3'b000, 2'b10, {32'hBBBB_0002, 32'hA5A5_0002});
      n_cmp++; if (s_stb_o !== 2'b10) begin n_fail++; $display("FAIL b2b_stb: got %b want 10", s_stb_o); end
      if (m_ack_o === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin n_fail++; $display("FAIL sb_b2b: unexpected ack, data %h", m_dat_o); end
         else begin want = exp_q.pop_front(); if (m_dat_o !== want) begin n_fail++; $display("FAIL sb_b2b: got %h want %h", m_dat_o, want); end end
      end
      drv(1'b0, 1'b0, 32'h0, 3'b000, 2'b00, 64'h0);
   endtask

   task automatic test_wait_states;
      for (int i = 0; i < 4; i++) begin
         // slave 0 chatters throughout; only slave 1's answer may pass
         if (i == 3) exp_q.push_back(32'hB0B0_0003);
         drv(1'b1, 1'b1, 32'hE000_0004, 3'b000, (i == 3) ? 2'b11 : 2'b01,
             {32'hB0B0_0000 + 32'(i), 32'hDEAD_0000 + 32'(i)});
         n_cmp++; if (s_stb_o !== 2'b10) begin n_fail++; $display("FAIL wait_stb[%0d]: got %b want 10", i, s_stb_o); end
         n_cmp++; if (m_ack_o !== (i == 3)) begin n_fail++; $display("FAIL wait_ack[%0d]: got %b want %b", i, m_ack_o, (i == 3)); end
         if (m_ack_o === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL sb_wait: unexpected ack, data %h", m_dat_o); end
            else begin want = exp_q.pop_front(); if (m_dat_o !== want) begin n_fail++; $display("FAIL sb_wait: got %h want %h", m_dat_o, want); end end
         end
      end
      drv(1'b0, 1'b0, 32'h0, 3'b000, 2'b00, 64'h0);
      n_cmp++; if (m_err_o !== 1'b0) begin n_fail++; $display("FAIL wait_after_err: got %b want 0", m_err_o); end
   endtask

   task automatic test_no_hit;
      drv(1'b1, 1'b1, 32'h9000_0000, 3'b000, 2'b11, {32'h1234_5678, 32'h8765_4321});
      n_cmp++; if (s_stb_o !== 2'b00) begin n_fail++; $display("FAIL nohit_stb: got %b want 00", s_stb_o); end
      n_cmp++; if (m_ack_o !== 1'b0 || m_rty_o !== 1'b0 || m_err_o !== 1'b0) begin n_fail++; $display("FAIL nohit_resp0: got ack %b rty %b err %b want 000", m_ack_o, m_rty_o, m_err_o); end
      n_cmp++; if (m_dat_o !== 32'h0) begin n_fail++; $display("FAIL nohit_dat: got %h want 0", m_dat_o); end
      drv(1'b1, 1'b1, 32'h9000_0000, 3'b000, 2'b11, {32'h1234_5678, 32'h8765_4321});
      n_cmp++; if (m_err_o !== 1'b1) begin n_fail++; $display("FAIL nohit_err: got %b want 1", m_err_o); end
      n_cmp++; if (s_stb_o !== 2'b00 || m_ack_o !== 1'b0) begin n_fail++; $display("FAIL nohit_errcyc: got stb %b ack %b want 00 0", s_stb_o, m_ack_o); end
      n_cmp++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL nohit_timeout: got %b want 0", timeout_o); end
      drv(1'b0, 1'b0, 32'h0, 3'b000, 2'b00, 64'h0);
      n_cmp++; if (m_err_o !== 1'b0) begin n_fail++; $display("FAIL nohit_err_once: got %b want 0", m_err_o); end
      exp_q.push_back(32'h0000_00AA);
      drv(1'b1, 1'b1, 32'h0000_0010, 3'b000, 2'b01, {32'h0000_00BB, 32'h0000_00AA});
      n_cmp++; if (m_ack_o !== 1'b1) begin n_fail++; $display("FAIL nohit_recover_ack: got %b want 1", m_ack_o); end
      if (m_ack_o === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin n_fail++; $display("FAIL sb_nohit: unexpected ack, data %h", m_dat_o); end
         else begin want = exp_q.pop_front(); if (m_dat_o !== want) begin n_fail++; $display("FAIL sb_nohit: got %h want %h", m_dat_o, want); end end
      end
      drv(1'b0, 1'b0, 32'h0, 3'b000, 2'b00, 64'h0);
   endtask

   task automatic test_timeout;
      // one IDLE cycle, four silent ACTIVE cycles, then the error cycle
      for (int i = 0; i < 6; i++) begin
         drv(1'b1, 1'b1, 32'h0000_0020, 3'b000, 2'b10, 64'h0);
         n_cmp++; if (m_err_o !== (i == 5)) begin n_fail++; $display("FAIL to_err[%0d]: got %b want %b", i, m_err_o, (i == 5)); end
         n_cmp++; if (timeout_o !== (i == 5)) begin n_fail++; $display("FAIL to_pulse[%0d]: got %b want %b", i, timeout_o, (i == 5)); end
         n_cmp++; if (s_stb_o !== ((i == 5) ? 2'b00 : 2'b01)) begin n_fail++; $display("FAIL to_stb[%0d]: got %b", i, s_stb_o); end
      end
      drv(1'b0, 1'b0, 32'h0, 3'b000, 2'b00, 64'h0);
      n_cmp++; if (m_err_o !== 1'b0 || timeout_o !== 1'b0) begin n_fail++; $display("FAIL to_once: got err %b to %b want 0 0", m_err_o, timeout_o); end
   endtask

   task automatic test_ack_at_limit;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) exp_q.push_back(32'h4C4C_0004);
         drv(1'b1, 1'b1, 32'h0000_0030, 3'b000, (i == 4) ? 2'b01 : 2'b00, {32'h0, 32'h4C4C_0004});
         n_cmp++; if (m_ack_o !== (i == 4) || m_err_o !== 1'b0) begin n_fail++; $display("FAIL lim_resp[%0d]: got ack %b err %b", i, m_ack_o, m_err_o); end
         if (m_ack_o === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL sb_lim: unexpected ack, data %h", m_dat_o); end
            else begin want = exp_q.pop_front(); if (m_dat_o !== want) begin n_fail++; $display("FAIL sb_lim: got %h want %h", m_dat_o, want); end end
         end
      end
      drv(1'b0, 1'b0, 32'h0, 3'b000, 2'b00, 64'h0);
      n_cmp++; if (m_err_o !== 1'b0 || timeout_o !== 1'b0) begin n_fail++; $display("FAIL lim_no_timeout: got err %b to %b want 0 0", m_err_o, timeout_o); end
   endtask

   task automatic test_burst;
      logic [31:0] adr_t[5];
      logic [2:0]  cti_t[5];
      adr_t = '{32'hE000_0000, 32'hE000_0000, 32'h0000_0004, 32'h0000_0008, 32'h0000_000C};
      cti_t = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b111};
      for (int i = 0; i < 5; i++) begin
         if (i > 0) exp_q.push_back(32'hB000_0000 + 32'(i));
         drv(1'b1, 1'b1, adr_t[i], cti_t[i], (i == 0) ? 2'b01 : 2'b11,
             {32'hB000_0000 + 32'(i), 32'hDEAD_0000 + 32'(i)});
         n_cmp++; if (s_stb_o !== 2'b10) begin n_fail++; $display("FAIL burst_stb[%0d]: got %b want 10", i, s_stb_o); end
         n_cmp++; if (m_ack_o !== (i > 0)) begin n_fail++; $display("FAIL burst_ack[%0d]: got %b want %b", i, m_ack_o, (i > 0)); end
         if (m_ack_o === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin n_fail++; $display("FAIL sb_burst: unexpected ack, data %h", m_dat_o); end
            else begin want = exp_q.pop_front(); if (m_dat_o !== want) begin n_fail++; $display("FAIL sb_burst[%0d]: got %h want %h", i, m_dat_o, want); end end
         end
      end
      // end-of-burst released the lock: the next beat decodes to slave 0
      exp_q.push_back(32'hDEAD_0005);
      drv(1'b1, 1'b1, 32'h0000_0004, 3'b000, 2'b11, {32'hB000_0005, 32'hDEAD_0005});
      n_cmp++; if (s_stb_o !== 2'b01) begin n_fail++; $display("FAIL burst_release_stb: got %b want 01", s_stb_o); end
      if (m_ack_o === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin n_fail++; $display("FAIL sb_release: unexpected ack, data %h", m_dat_o); end
         else begin want = exp_q.pop_front(); if (m_dat_o !== want) begin n_fail++; $display("FAIL sb_release: got %h want %h", m_dat_o, want); end end
      end
      drv(1'b0, 1'b0, 32'h0, 3'b000, 2'b00, 64'h0);
   endtask

   task automatic test_abort;
      drv(1'b1, 1'b1, 32'hE000_0008, 3'b000, 2'b00, 64'h0);
      drv(1'b0, 1'b0, 32'hE000_0008, 3'b000, 2'b00, 64'h0);
      n_cmp++; if (m_err_o !== 1'b0) begin n_fail++; $display("FAIL abort_err: got %b want 0", m_err_o); end
      exp_q.push_back(32'h0AB0_0000);
      drv(1'b1, 1'b1, 32'h0000_0010, 3'b000, 2'b01, {32'h0, 32'h0AB0_0000});
      n_cmp++; if (s_stb_o !== 2'b01) begin n_fail++; $display("FAIL abort_redecode_stb: got %b want 01", s_stb_o); end
      if (m_ack_o === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin n_fail++; $display("FAIL sb_abort: unexpected ack, data %h", m_dat_o); end
         else begin want = exp_q.pop_front(); if (m_dat_o !== want) begin n_fail++; $display("FAIL sb_abort: got %h want %h", m_dat_o, want); end end
      end
      drv(1'b0, 1'b0, 32'h0, 3'b000, 2'b00, 64'h0);
   endtask

   task automatic test_overlap_reset;
      drv(1'b0, 1'b0, 32'h0, 3'b000, 2'b00, 64'h0);
      drv(1'b1, 1'b1, 32'hE000_0000, 3'b000, 2'b00, 64'h0);
      n_cmp++; if (b_s_stb !== 2'b01) begin n_fail++; $display("FAIL overlap_stb: got %b want 01", b_s_stb); end
      // both DUTs are now mid-transfer; reset abandons it
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0; m_cyc_i = 1'b0; m_stb_i = 1'b0;
      @(negedge clk);
      n_cmp++; if (b_err !== 1'b0 || b_timeout !== 1'b0) begin n_fail++; $display("FAIL overlap_rst_err: got err %b to %b want 0 0", b_err, b_timeout); end
      n_cmp++; if (m_err_o !== 1'b0 || timeout_o !== 1'b0) begin n_fail++; $display("FAIL rst_active_err: got err %b to %b want 0 0", m_err_o, timeout_o); end
      drv(1'b0, 1'b0, 32'h0, 3'b000, 2'b00, 64'h0);
      n_cmp++; if (b_err !== 1'b0 || m_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_late_err: got b %b a %b want 0 0", b_err, m_err_o); end
      exp_q.push_back(32'h6B6B_0000);
      drv(1'b1, 1'b1, 32'hE000_0000, 3'b000, 2'b11, {32'h6B6B_0000, 32'h5A5A_0000});
      n_cmp++; if (b_s_stb !== 2'b01 || b_ack !== 1'b1) begin n_fail++; $display("FAIL overlap_sel: got stb %b ack %b want 01 1", b_s_stb, b_ack); end
      n_cmp++; if (b_dat !== 32'h5A5A_0000) begin n_fail++; $display("FAIL overlap_dat: got %h want 5a5a0000", b_dat); end
      if (m_ack_o === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin n_fail++; $display("FAIL sb_overlap: unexpected ack, data %h", m_dat_o); end
         else begin want = exp_q.pop_front(); if (m_dat_o !== want) begin n_fail++; $display("FAIL sb_overlap: got %h want %h", m_dat_o, want); end end
      end
      drv(1'b0, 1'b0, 32'h0, 3'b000, 2'b00, 64'h0);
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_wait_states();
      test_no_hit();
      test_timeout();
      test_ack_at_limit();
      test_burst();
      test_abort();
      test_overlap_reset();
      n_cmp++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_drain: %0d expected acks never seen, want 0", exp_q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ct_select_n.md
CT_SELECT_N -- requirements
Module: ct_select_n

Interface
REQ-001 Parameter SLAVES, default 2: number of slave ports, range 1..16.
REQ-002 Parameter S_BASE, default {4'hE,28'h0,32'h0}: SLAVES x 32-bit base addresses, slave i at bits [32i+31:32i].
REQ-003 Parameter S_MASK, default {32'hF000_0000,32'h8000_0000}: SLAVES x 32-bit masks; slave i hits when (m_adr_i & mask_i) == (base_i & mask_i).
REQ-004 Parameter TIMEOUT, default 255: response timeout in cycles, 0 = disabled; the counter is 8 bits wide.
REQ-005 clk  in  1  single clock; every register updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 m_dat_i/m_adr_i in 32, m_sel_i in 4, m_we_i/m_cyc_i/m_stb_i in 1, m_cti_i in 3, m_bte_i in 2  Wishbone master request.
REQ-008 m_ack_o/m_err_o/m_rty_o  out  1  master response; m_dat_o  out  32  read data.
REQ-009 s_dat_o/s_adr_o  out  SLAVES*32, s_sel_o  out  SLAVES*4, s_we_o/s_cyc_o/s_stb_o  out  SLAVES, s_cti_o  out  SLAVES*3, s_bte_o  out  SLAVES*2  flattened slave requests, slave i at slice i.
REQ-010 s_ack_i/s_err_i/s_rty_i  in  SLAVES, s_dat_i  in  SLAVES*32  flattened slave responses.
REQ-011 timeout_o  out  1  one-cycle pulse when a timeout error is issued.

Function
REQ-012 dat, adr, sel, we, cyc, cti and bte shall be broadcast unmodified to every slave.
REQ-013 Decode shall be priority-encoded: the lowest hitting index wins on overlapping windows.
REQ-014 FSM states: IDLE, ACTIVE, ERROR.
REQ-015 Active slave index: the combinational decode in IDLE; the latched index in ACTIVE.
REQ-016 s_stb_o[k] = m_stb_i & (state != ERROR) & (k == active index) & hit; no other slave stb shall be asserted.
REQ-017 m_ack_o, m_rty_o and m_dat_o shall be taken combinationally from the active slave; m_err_o = active s_err_i OR (state == ERROR).
REQ-018 IDLE, m_cyc_i & m_stb_i, hit, response in the same cycle: stay IDLE (zero added latency).
REQ-019 IDLE, m_cyc_i & m_stb_i, hit, no response: latch the index and go to ACTIVE.
REQ-020 IDLE, m_cyc_i & m_stb_i, no hit: go to ERROR; no slave is strobed; m_ack_o = m_rty_o = 0 and m_dat_o = 0 in that cycle.
REQ-021 ACTIVE, response (ack/err/rty) with m_cti_i of 000 or 111: go to IDLE, so the next beat is re-decoded.
REQ-022 ACTIVE, response with m_cti_i of 001 or 010: stay ACTIVE with the same slave (burst locked).
REQ-023 ACTIVE, m_cyc_i = 0: go to IDLE immediately (abort); no error is issued.
REQ-024 Timeout counter: cleared in IDLE and on any response; increments each ACTIVE cycle with m_stb_i = 1 and no response.
REQ-025 When the counter equals TIMEOUT-1 with no response (TIMEOUT != 0): go to ERROR and pulse timeout_o in the ERROR cycle.
REQ-026 ERROR: lasts exactly one cycle with m_err_o = 1, m_ack_o = m_rty_o = 0, all s_stb_o = 0; then go to IDLE.
REQ-027 A slave ack arriving in the same cycle the counter reaches its limit shall win: it is forwarded and no timeout occurs.
REQ-028 Slave responses while the slave is not active shall be ignored.
REQ-029 In IDLE with m_stb_i = 0: all responses shall be 0 and m_dat_o shall be 0.

Reset
REQ-030 With rst high at a clock edge: state = IDLE, counter = 0, latched index = 0, timeout_o = 0.
REQ-031 After reset, m_err_o shall be 0 until the next master strobe.
REQ-032 Reset asserted mid-ACTIVE or in ERROR shall abandon the transfer with no error pulse.

Verification
REQ-033 Single read, adr 0x0000_0010, slave 0 acks in cycle 1 -> s_stb_o = 2'b01, m_ack_o in the same cycle, FSM stays IDLE.
REQ-034 adr 0xE000_0004, slave 1 acks after 3 wait cycles -> ACTIVE for 3 cycles, m_dat_o = s_1 data on ack, then IDLE.
REQ-035 adr 0x9000_0000 (no hit) -> s_stb_o = 0, m_err_o = 1 exactly one cycle later, then IDLE.
REQ-036 TIMEOUT = 4, slave 0 never responds -> ERROR after 4 ACTIVE cycles, m_err_o and timeout_o pulsed once, s_stb_o deasserted.
REQ-037 Incrementing burst (cti 010 x3, then 111) to slave 1 while the address crosses into the slave 0 window -> all 4 beats go to slave 1.
REQ-038 Overlapping windows (both masks 0) -> slave 0 always selected; rst during ACTIVE -> IDLE with no err pulse.
